// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, sticky error
// flags, synchronous flush and selectable first-word-fall-through read.
module fifo_sync_param #(
    parameter int pWidth       = 8,
    parameter int pFifoDepth   = 8,
    parameter int pAlmostFull  = 6,
    parameter int pAlmostEmpty = 2,
    parameter int pFwft        = 0,
    localparam int pAddrW      = $clog2(pFifoDepth),
    localparam int pLevelW     = pAddrW + 1
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iClr,
    input  logic               iWrEn,
    input  logic [pWidth-1:0]  iWrData,
    output logic               oWrFull,
    output logic               oWrAlmostFull,
    input  logic               iRdEn,
    output logic [pWidth-1:0]  oRdData,
    output logic               oRdEmpty,
    output logic               oRdAlmostEmpty,
    output logic [pLevelW-1:0] oLevel,
    output logic               oOverflow,
    output logic               oUnderflow
);

    localparam logic [pLevelW-1:0] depth_l = pLevelW'(pFifoDepth);
    localparam logic [pLevelW-1:0] afull_l = pLevelW'(pAlmostFull);
    localparam logic [pLevelW-1:0] aempty_l = pLevelW'(pAlmostEmpty);

    logic [pWidth-1:0]  mem [pFifoDepth];
    logic [pAddrW-1:0]  wr_ptr;
    logic [pAddrW-1:0]  rd_ptr;
    logic [pLevelW-1:0] level;
    logic [pLevelW-1:0] level_next;
    logic               rd_acc;
    logic               wr_acc;
    logic               ovf;
    logic               udf;

    assign oLevel         = level;
    assign oWrFull        = (level == depth_l);
    assign oWrAlmostFull  = (level >= afull_l);
    assign oRdEmpty       = (level == '0);
    assign oRdAlmostEmpty = (level <= aempty_l);
    assign oOverflow      = ovf;
    assign oUnderflow     = udf;

    // Flush suppresses both accepts; a full FIFO still takes a write alongside a read.
    assign rd_acc = iRdEn & ~iClr & ~oRdEmpty;
    assign wr_acc = iWrEn & ~iClr & (~oWrFull | rd_acc);

    always_comb begin
        level_next = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_next = level + pLevelW'(1);
            2'b01:   level_next = level - pLevelW'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (iClr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + pAddrW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + pAddrW'(1);
            level <= level_next;
            if (iWrEn && !wr_acc) ovf <= 1'b1;
            if (iRdEn && !rd_acc) udf <= 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (wr_acc) mem[wr_ptr] <= iWrData;
    end

    generate
        if (pFwft != 0) begin : g_fwft
            assign oRdData = mem[rd_ptr];
        end else begin : g_std
            logic [pWidth-1:0] rd_q;
            always_ff @(posedge iClk or posedge iRst) begin
                if (iRst)        rd_q <= '0;
                else if (iClr)   rd_q <= '0;
                else if (rd_acc) rd_q <= mem[rd_ptr];
            end
            assign oRdData = rd_q;
        end
    endgenerate

endmodule
